// File: rtl/norm_stage.sv
// Post-add normalization stage: fixes a carry-out with a sticky right shift, or
// left-shifts one bit per cycle until the hidden bit is set or the exponent bottoms out.
module norm_stage #(
  parameter int Significant_WD = 23,
  parameter int Exp_WD         = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Significant_WD+4:0] in_sig,
  input  logic [Exp_WD-1:0]         in_exp,
  input  logic                      in_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Significant_WD+3:0] out_sig,
  output logic [Exp_WD-1:0]         out_exp,
  output logic                      out_sign,
  output logic                      out_zero,
  output logic                      out_denorm,
  output logic                      out_ovf
);

  localparam int VW     = Significant_WD + 5;
  localparam int CARRY  = VW - 1;
  localparam int HIDDEN = VW - 2;
  localparam logic [Exp_WD-1:0] EXP_ONE = Exp_WD'(1);
  localparam logic [Exp_WD-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  // The carry bit is always zero once an operand has been accepted, so the
  // working vector only keeps hidden + fraction + guard bits.
  logic [Significant_WD+3:0] sig_q, sig_d;
  logic [Exp_WD-1:0]         exp_q, exp_d;
  logic                      sign_q, sign_d;
  logic                      zero_q, zero_d;
  logic                      denorm_q, denorm_d;
  logic                      ovf_q, ovf_d;

  logic [Significant_WD+3:0] sig_shl;
  logic [Exp_WD-1:0]         exp_dec;
  logic [Exp_WD-1:0]         exp_inc;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge value; the datapath is reset too because the
  // outputs are required to read zero while in reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sig_shl = {sig_q[Significant_WD+2:0], 1'b0};
  assign exp_dec = exp_q - EXP_ONE;
  assign exp_inc = in_exp + EXP_ONE;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sig_d    = in_sig[Significant_WD+3:0];
          exp_d    = in_exp;
          sign_d   = in_sign;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = DONE;
          if (in_sig[CARRY]) begin
            // Bits shifted out of the guard position fold into the sticky bit.
            sig_d = {in_sig[CARRY:2], in_sig[1] | in_sig[0]};
            exp_d = exp_inc;
            ovf_d = (exp_inc == EXP_MAX);
          end else if (in_sig == '0) begin
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (in_sig[HIDDEN]) begin
            state_d = DONE;
          end else if (in_exp <= EXP_ONE) begin
            denorm_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sig_d = sig_shl;
        exp_d = exp_dec;
        if (sig_shl[HIDDEN]) begin
          state_d = DONE;
        end else if (exp_dec == EXP_ONE) begin
          state_d  = DONE;
          denorm_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_sig    = sig_q;
    out_exp    = exp_q;
    out_sign   = sign_q;
    out_zero   = zero_q;
    out_denorm = denorm_q;
    out_ovf    = ovf_q;
  end

endmodule
